teatimer_fb_writer: RTL and testbench
=====================================

Name: teatimer_fb_writer

Overview:
Write-side producer for the neopixel framebuf BRAM. It runs the tea countdown from the start/stop switches and a 1 Hz strobe. On every visible change it rewrites the whole framebuf, one byte per clk_20M cycle, as a GRB bar graph of the remaining time. The neopixel engine on the BRAM read port streams the result to the LEDs. The block sits beside that engine, on the framebuf write port.

Parameters:
NUM_LEDS, 60, LEDs in the strip; framebuf uses bytes 0..3*NUM_LEDS-1 (max 170).
TEA_SECONDS, 240, countdown length in seconds (1..1023).
BRIGHT, 8'h20, byte value written for a lit colour channel.

Ports:
clk_20M  input  1  system clock, 20 MHz PLL output.
rst  input  1  asynchronous, active-high reset.
tick_1hz  input  1  one-cycle strobe once per second, synchronous to clk_20M.
sw_start  input  1  raw start button, active-high, asynchronous.
sw_stop  input  1  raw stop button, active-high, asynchronous.
w_addr  output  9  framebuf write address.
din  output  8  framebuf write data.
write_en  output  1  framebuf write strobe; the byte is written on the clk_20M edge while it is high.
busy  output  1  redraw in progress.
done  output  1  high while in state DONE.

Behaviour:
- Clocking/reset: one clock, clk_20M; reset is asynchronous and active-high (rst). While rst is high: state=IDLE, remaining=0, phase=0, w_addr=0, din=0, write_en=0, busy=0, done=0, pending=1.
- Switches: each passes through a 2-FF synchronizer. A press is the rising edge of the synchronized signal, giving a one-cycle press strobe. A press is acted on 3 cycles after the raw edge.
- Timer FSM, priority stop > start > tick:
  - IDLE: start press -> RUNNING, remaining=TEA_SECONDS. Ticks are ignored.
  - RUNNING: start press reloads remaining=TEA_SECONDS and the same-cycle tick is discarded. On tick, remaining decrements; at 1->0, go to DONE with phase=1.
  - DONE: each tick toggles phase. A start press -> RUNNING with reload.
  - Any state: stop press -> IDLE, remaining=0.
- Redraw request: pending is set on every FSM state change, every remaining change, every phase toggle, and out of reset.
- Redraw FSM (R_IDLE, R_WRITE):
  - R_IDLE with pending=1: the next cycle enters R_WRITE, clears pending, and snapshots state/remaining/phase.
  - Requests arriving during R_WRITE set pending again, so exactly one further redraw follows. The frame in flight uses only the snapshot, so it is never torn.
- R_WRITE:
  - write_en=1 and busy=1 for exactly 3*NUM_LEDS consecutive cycles.
  - w_addr runs 0,1,2,... in order; byte 3*i+k is LED i, channel k (0=G, 1=R, 2=B).
  - After the last byte: write_en=0, busy=0, w_addr=0, return to R_IDLE.
- Pixel colours:
  - IDLE: all bytes 0.
  - RUNNING: LED i is lit when i*TEA_SECONDS < remaining*NUM_LEDS. Lit = G=BRIGHT, R=0, B=0; unlit = all 0.
  - DONE, phase=1: every LED is R=BRIGHT, G=B=0. DONE, phase=0: all 0.
- Arithmetic: the i*TEA_SECONDS term is an accumulator that adds TEA_SECONDS per LED (no multiplier in the loop). Compare at 20 bits unsigned; no truncation is allowed.
- done: registered, equal to (state==DONE).

Test Plan:
1. Reset released, no stimulus -> write_en high for 180 cycles, addr 0..179, all din=0; then busy=0 and no further writes.
2. Start press in IDLE, wait for redraw -> the 180 bytes are G=0x20, R=B=0 for LEDs 0..59 (remaining=240). After 120 ticks, the redraw lights LEDs 0..29 only; byte 90 (LED30 G) = 0.
3. Remaining=1, then one tick -> done=1 and all LEDs R=0x20. The next tick redraws all-zero; the tick after that redraws all-red.
4. Stop and start strobes in the same cycle while RUNNING -> IDLE, remaining=0, all-zero frame written, done=0.
5. Tick arrives mid-redraw (cycle 50 of 180) -> the current frame completes unchanged from its snapshot. Exactly one more 180-cycle frame follows immediately with the new count.
6. rst asserted at cycle 100 of a redraw -> write_en=0 asynchronously. After release, a full all-zero 180-byte frame is written.

Source files
------------

// File: rtl/teatimer_fb_writer.sv
// Tea countdown timer that redraws the neopixel framebuf as a GRB bar graph
// whenever the visible state changes, one byte per clk_20M cycle.
module teatimer_fb_writer #(
  parameter int          NUM_LEDS    = 60,
  parameter int          TEA_SECONDS = 240,
  parameter logic [7:0]  BRIGHT      = 8'h20
) (
  input  logic       clk_20M,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       sw_start,
  input  logic       sw_stop,
  output logic [8:0] w_addr,
  output logic [7:0] din,
  output logic       write_en,
  output logic       busy,
  output logic       done
);

  localparam logic [8:0]  LAST_ADDR = 9'(3 * NUM_LEDS - 1);
  localparam logic [9:0]  TEA_LOAD  = 10'(TEA_SECONDS);
  localparam logic [19:0] TEA_STEP  = 20'(TEA_SECONDS);
  localparam logic [19:0] NUM_W     = 20'(NUM_LEDS);

  typedef enum logic [1:0] {IDLE, RUNNING, DONE} tstate_e;
  typedef enum logic {R_IDLE, R_WRITE} rstate_e;

  tstate_e     state_q, state_d, snap_state_q, snap_state_d;
  rstate_e     rstate_q, rstate_d;
  logic [9:0]  rem_q, rem_d;
  logic        phase_q, phase_d, snap_phase_q, snap_phase_d;
  logic        pending_q, pending_d;
  logic [2:0]  start_sync_q, start_sync_d, stop_sync_q, stop_sync_d;
  logic [19:0] thresh_q, thresh_d, acc_q, acc_d;
  logic [1:0]  ch_q, ch_d;
  logic [8:0]  w_addr_q, w_addr_d;
  logic [7:0]  din_q, din_d;
  logic        write_en_q, write_en_d, busy_q, busy_d, done_q, done_d;
  logic        start_p, stop_p, req;
  logic [1:0]  ch_n;
  logic [19:0] acc_n;

  function automatic logic [7:0] pixel_byte(tstate_e st, logic ph, logic lit, logic [1:0] ch);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      RUNNING: if (lit && ch == 2'd0) b = BRIGHT;
      DONE:    if (ph && ch == 2'd1) b = BRIGHT;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign start_p = start_sync_q[1] & ~start_sync_q[2];
  assign stop_p  = stop_sync_q[1] & ~stop_sync_q[2];

  always_comb begin
    start_sync_d = {start_sync_q[1:0], sw_start};
    stop_sync_d  = {stop_sync_q[1:0], sw_stop};
    state_d      = state_q;
    rem_d        = rem_q;
    phase_d      = phase_q;

    if (stop_p) begin
      state_d = IDLE;
      rem_d   = 10'd0;
      phase_d = 1'b0;
    end else if (start_p) begin
      state_d = RUNNING;
      rem_d   = TEA_LOAD;
      phase_d = 1'b0;
    end else if (tick_1hz) begin
      case (state_q)
        RUNNING: begin
          if (rem_q == 10'd1) begin
            state_d = DONE;
            rem_d   = 10'd0;
            phase_d = 1'b1;
          end else begin
            rem_d = rem_q - 10'd1;
          end
        end
        DONE:    phase_d = ~phase_q;
        default: state_d = state_q;
      endcase
    end

    req = (state_d != state_q) || (rem_d != rem_q) || (phase_d != phase_q);

    rstate_d     = rstate_q;
    pending_d    = pending_q;
    snap_state_d = snap_state_q;
    snap_phase_d = snap_phase_q;
    thresh_d     = thresh_q;
    acc_d        = acc_q;
    ch_d         = ch_q;
    w_addr_d     = w_addr_q;
    din_d        = din_q;
    write_en_d   = write_en_q;
    busy_d       = busy_q;
    ch_n         = (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
    acc_n        = (ch_q == 2'd2) ? acc_q + TEA_STEP : acc_q;

    case (rstate_q)
      R_IDLE: begin
        if (pending_q) begin
          // Byte 0 is emitted on the entry edge, so it is built from the live values being snapshotted.
          rstate_d     = R_WRITE;
          pending_d    = 1'b0;
          snap_state_d = state_q;
          snap_phase_d = phase_q;
          thresh_d     = 20'(rem_q) * NUM_W;
          acc_d        = 20'd0;
          ch_d         = 2'd0;
          w_addr_d     = 9'd0;
          write_en_d   = 1'b1;
          busy_d       = 1'b1;
          din_d        = pixel_byte(state_q, phase_q, rem_q != 10'd0, 2'd0);
        end
      end
      R_WRITE: begin
        if (w_addr_q == LAST_ADDR) begin
          rstate_d   = R_IDLE;
          write_en_d = 1'b0;
          busy_d     = 1'b0;
          w_addr_d   = 9'd0;
          din_d      = 8'h00;
        end else begin
          w_addr_d = w_addr_q + 9'd1;
          ch_d     = ch_n;
          acc_d    = acc_n;
          din_d    = pixel_byte(snap_state_q, snap_phase_q, acc_n < thresh_q, ch_n);
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    pending_d = pending_d | req;
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk_20M or posedge rst) begin
    if (rst) begin
      start_sync_q <= 3'b000;
      stop_sync_q  <= 3'b000;
      state_q      <= IDLE;
      rem_q        <= 10'd0;
      phase_q      <= 1'b0;
      rstate_q     <= R_IDLE;
      pending_q    <= 1'b1;
      snap_state_q <= IDLE;
      snap_phase_q <= 1'b0;
      thresh_q     <= 20'd0;
      acc_q        <= 20'd0;
      ch_q         <= 2'd0;
      w_addr_q     <= 9'd0;
      din_q        <= 8'h00;
      write_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_sync_q <= start_sync_d;
      stop_sync_q  <= stop_sync_d;
      state_q      <= state_d;
      rem_q        <= rem_d;
      phase_q      <= phase_d;
      rstate_q     <= rstate_d;
      pending_q    <= pending_d;
      snap_state_q <= snap_state_d;
      snap_phase_q <= snap_phase_d;
      thresh_q     <= thresh_d;
      acc_q        <= acc_d;
      ch_q         <= ch_d;
      w_addr_q     <= w_addr_d;
      din_q        <= din_d;
      write_en_q   <= write_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign w_addr   = w_addr_q;
  assign din      = din_q;
  assign write_en = write_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_teatimer_fb_writer.sv
// Randomised and directed bench for teatimer_fb_writer, checked against a
// behavioural timer/frame model every cycle.
module tb_teatimer_fb_writer;
  localparam int N  = 60;
  localparam int T  = 240;
  localparam int NB = 3 * N;
  localparam int BR = 8'h20;

  logic       clk_20M = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       sw_start = 1'b0;
  logic       sw_stop = 1'b0;
  logic [8:0] w_addr;
  logic [7:0] din;
  logic       write_en, busy, done;

  teatimer_fb_writer #(.NUM_LEDS(N), .TEA_SECONDS(T), .BRIGHT(8'h20)) dut (
    .clk_20M(clk_20M), .rst(rst), .tick_1hz(tick_1hz), .sw_start(sw_start),
    .sw_stop(sw_stop), .w_addr(w_addr), .din(din), .write_en(write_en),
    .busy(busy), .done(done)
  );

  always #25 clk_20M = ~clk_20M;

  int total = 0;
  int bad = 0;

  // model: 0=IDLE 1=RUNNING 2=DONE
  int m_state = 0, m_rem = 0, m_ph = 0;
  int p_state = 0, p_rem = 0, p_ph = 0;
  int cyc = 0;
  int start_at[$];
  int stop_at[$];

  bit in_frame = 0;
  int idx = 0, frames = 0;
  int f_state, f_rem, f_ph;
  int fbuf [NB];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_byte(int st, int rem, int ph, int a);
    int led = a / 3;
    int ch = a % 3;
    if (st == 1) return (ch == 0 && led * T < rem * N) ? BR : 0;
    if (st == 2) return (ph != 0 && ch == 1) ? BR : 0;
    return 0;
  endfunction

  always @(posedge clk_20M or posedge rst) begin
    if (rst) begin
      m_state = 0; m_rem = 0; m_ph = 0;
      p_state = 0; p_rem = 0; p_ph = 0;
      start_at.delete();
      stop_at.delete();
    end else begin
      bit st, sp;
      cyc++;
      p_state = m_state; p_rem = m_rem; p_ph = m_ph;
      st = 0; sp = 0;
      if (start_at.size() > 0 && start_at[0] == cyc) begin st = 1; void'(start_at.pop_front()); end
      if (stop_at.size() > 0 && stop_at[0] == cyc) begin sp = 1; void'(stop_at.pop_front()); end
      if (sp) begin
        m_state = 0; m_rem = 0; m_ph = 0;
      end else if (st) begin
        m_state = 1; m_rem = T; m_ph = 0;
      end else if (tick_1hz) begin
        if (m_state == 1) begin
          m_rem--;
          if (m_rem == 0) begin m_state = 2; m_ph = 1; end
        end else if (m_state == 2) begin
          m_ph = 1 - m_ph;
        end
      end
    end
  end

  always @(negedge clk_20M) begin
    if (rst) begin
      in_frame = 0;
    end else begin
      chk("done", done, (m_state == 2) ? 1 : 0);
      chk("busy_vs_we", busy, write_en);
      if (write_en) begin
        if (!in_frame) begin
          in_frame = 1; idx = 0;
          f_state = p_state; f_rem = p_rem; f_ph = p_ph;
        end
        if (idx < NB) begin
          chk("w_addr", w_addr, idx);
          chk("din", din, exp_byte(f_state, f_rem, f_ph, idx));
          fbuf[idx] = din;
        end else begin
          chk("frame_overrun", idx, NB - 1);
        end
        idx++;
      end else begin
        chk("idle_addr", w_addr, 0);
        if (in_frame) begin
          chk("frame_len", idx, NB);
          in_frame = 0;
          frames++;
        end
      end
    end
  end

  task automatic wait_quiet();
    int q = 0, n = 0;
    while (q < 3 && n < 5000) begin
      @(negedge clk_20M);
      n++;
      if (busy) q = 0; else q++;
    end
    if (q < 3) begin
      total++; bad++;
      $display("FAIL quiet_timeout busy still=%0d after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 2000) begin @(negedge clk_20M); n++; end
    if (!busy) begin
      total++; bad++;
      $display("FAIL busy_timeout busy=%0d required 1", busy);
    end
  endtask

  task automatic check_final(string name);
    int errs = 0;
    for (int a = 0; a < NB; a++)
      if (fbuf[a] != exp_byte(m_state, m_rem, m_ph, a)) errs++;
    chk(name, errs, 0);
  endtask

  task automatic do_tick();
    @(negedge clk_20M); tick_1hz = 1'b1;
    @(negedge clk_20M); tick_1hz = 1'b0;
  endtask

  task automatic press(bit s, bit p);
    @(negedge clk_20M);
    if (p) begin sw_stop = 1'b1; stop_at.push_back(cyc + 3); end
    if (s) begin sw_start = 1'b1; start_at.push_back(cyc + 3); end
    repeat (4) @(negedge clk_20M);
    sw_start = 1'b0; sw_stop = 1'b0;
    repeat (4) @(negedge clk_20M);
  endtask

  initial begin
    int f0, hold;
    repeat (3) @(negedge clk_20M);
    #1 chk("reset_we", write_en, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    // T1: power-up frame
    wait_quiet();
    chk("t1_frames", frames, 1);
    check_final("t1_zero_frame");
    repeat (20) @(negedge clk_20M);
    chk("t1_no_more", frames, 1);

    // T2: start and count down halfway
    press(1, 0);
    wait_quiet();
    chk("t2_led0_g", fbuf[0], 32);
    chk("t2_led59_g", fbuf[177], 32);
    chk("t2_led0_r", fbuf[1], 0);
    check_final("t2_full");
    repeat (120) do_tick();
    wait_quiet();
    chk("t2_led29_g", fbuf[87], 32);
    chk("t2_led30_g", fbuf[90], 0);
    check_final("t2_half");

    // T3: expire and blink
    repeat (119) do_tick();
    wait_quiet();
    chk("t3_one_left_led0", fbuf[0], 32);
    chk("t3_one_left_led1", fbuf[3], 0);
    do_tick();
    wait_quiet();
    chk("t3_done", done, 1);
    chk("t3_red", fbuf[1], 32);
    chk("t3_green", fbuf[0], 0);
    do_tick();
    wait_quiet();
    chk("t3_blink_off", fbuf[1], 0);
    do_tick();
    wait_quiet();
    chk("t3_blink_on", fbuf[4], 32);
    check_final("t3_final");

    // T4: stop beats start in the same cycle
    press(1, 0);
    wait_quiet();
    press(1, 1);
    wait_quiet();
    chk("t4_done", done, 0);
    chk("t4_zero", fbuf[0], 0);
    check_final("t4_final");

    // T5: tick mid-redraw
    press(1, 0);
    wait_quiet();
    f0 = frames;
    do_tick();
    wait_busy();
    repeat (49) @(negedge clk_20M);
    do_tick();
    wait_quiet();
    chk("t5_two_frames", frames, f0 + 2);
    check_final("t5_final");

    // T6: reset mid-redraw
    do_tick();
    wait_busy();
    repeat (100) @(negedge clk_20M);
    #5 rst = 1'b1;
    #1 chk("t6_we_async", write_en, 0);
    chk("t6_busy_async", busy, 0);
    f0 = frames;
    repeat (2) @(negedge clk_20M);
    rst = 1'b0;
    wait_quiet();
    chk("t6_frames", frames, f0 + 1);
    check_final("t6_zero");

    // Random traffic
    hold = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk_20M);
      tick_1hz = ($urandom_range(0, 3) == 0);
      if (hold > 0) begin
        hold--;
      end else if (sw_start || sw_stop) begin
        sw_start = 1'b0; sw_stop = 1'b0; hold = 4;
      end else begin
        int r = $urandom_range(0, 299);
        if (r < 3) begin
          if (r != 0) begin sw_start = 1'b1; start_at.push_back(cyc + 3); end
          if (r != 1) begin sw_stop = 1'b1; stop_at.push_back(cyc + 3); end
          hold = 4;
        end else if (r < 9 && m_state == 0) begin
          sw_start = 1'b1; start_at.push_back(cyc + 3); hold = 4;
        end
      end
    end
    @(negedge clk_20M);
    tick_1hz = 1'b0; sw_start = 1'b0; sw_stop = 1'b0;
    repeat (5) @(negedge clk_20M);
    wait_quiet();
    check_final("rand_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
